uart_axis_packer: RTL and testbench

- Packs the PULPino UART receive byte stream (one byte per strobe from the loading-file controller) into full-width AXI4-Stream beats with byte-accurate tkeep.
- Replaces the current one-byte-per-512-bit-beat path into the output xpm_fifo_axis, cutting host-side bandwidth and memory waste.
- Beats are emitted when full, after an idle timeout, or on program-done (gpio_out[8] rising edge), which also closes the packet with tlast.

---
 rtl/uart_axis_packer.sv | 126 ++++++++++++
 tb/tb_uart_axis_packer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_axis_packer.sv
// Packs a UART byte stream into full-width AXI4-Stream beats with byte-accurate tkeep.
// Partial beats are flushed on idle timeout or on a done rising edge, which also sets tlast.
module uart_axis_packer #(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 512,
    parameter int unsigned C_IDLE_TIMEOUT     = 1024,
    parameter int unsigned C_CNT_WIDTH        = 16
) (
    input  logic                            s_axis_aclk,
    input  logic                            rst_n,
    input  logic                            byte_valid_i,
    input  logic [7:0]                      byte_data_i,
    input  logic                            done_i,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                            m_axis_tlast,
    output logic [C_CNT_WIDTH-1:0]          overflow_cnt_o,
    output logic                            busy_o
);
    localparam int unsigned NB = C_AXIS_TDATA_WIDTH / 8;
    localparam int unsigned FW = $clog2(NB + 1);
    localparam int unsigned TW = (C_IDLE_TIMEOUT > 1) ? $clog2(C_IDLE_TIMEOUT + 1) : 1;
    localparam logic [FW-1:0] FillFull = FW'(NB);
    localparam logic [TW-1:0] IdleMax  = TW'(C_IDLE_TIMEOUT);

    logic [C_AXIS_TDATA_WIDTH-1:0] acc_q, acc_d;
    logic [FW-1:0]                 fill_q, fill_d;
    logic [TW-1:0]                 idle_q, idle_d;
    logic                          last_pend_q, last_pend_d;
    logic                          done_q;
    logic                          out_valid_q, out_valid_d;
    logic [C_AXIS_TDATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [NB-1:0]                 out_keep_q, out_keep_d;
    logic                          out_last_q, out_last_d;
    logic [C_CNT_WIDTH-1:0]        ovf_q, ovf_d;
    logic [NB-1:0]                 keep_fill;

    logic full, timeout, flush_req, slot_free, xfer, accept, done_rise;

    assign full      = (fill_q == FillFull);
    assign timeout   = (C_IDLE_TIMEOUT != 0) && (fill_q != '0) && !full && (idle_q == IdleMax);
    assign flush_req = full || timeout || last_pend_q;
    assign slot_free = !out_valid_q || m_axis_tready;
    assign xfer      = flush_req && slot_free;
    // A byte arriving in the transfer cycle starts the next beat rather than being dropped.
    assign accept    = byte_valid_i && (!full || xfer);
    assign done_rise = done_i && !done_q;

    always_comb begin
        for (int unsigned i = 0; i < NB; i++) begin
            keep_fill[i] = (FW'(i) < fill_q);
        end

        acc_d  = xfer ? '0 : acc_q;
        fill_d = xfer ? '0 : fill_q;
        if (accept) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (FW'(i) == fill_d) begin
                    acc_d[8*i +: 8] = byte_data_i;
                end
            end
            fill_d = fill_d + FW'(1);
        end

        idle_d = idle_q;
        if (accept || xfer) begin
            idle_d = '0;
        end else if ((fill_q != '0) && !full && (idle_q != IdleMax)) begin
            idle_d = idle_q + TW'(1);
        end

        // A repeated done edge while a flush is already pending is absorbed.
        last_pend_d = last_pend_q ? !xfer : done_rise;

        out_valid_d = out_valid_q && !m_axis_tready;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_q;
            out_keep_d  = keep_fill;
            out_last_d  = last_pend_q;
        end

        ovf_d = ovf_q;
        if (byte_valid_i && !accept && (ovf_q != '1)) begin
            ovf_d = ovf_q + C_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge s_axis_aclk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            fill_q      <= '0;
            idle_q      <= '0;
            last_pend_q <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            ovf_q       <= '0;
        end else begin
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            idle_q      <= idle_d;
            last_pend_q <= last_pend_d;
            done_q      <= done_i;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            ovf_q       <= ovf_d;
        end
    end

    assign m_axis_tvalid  = out_valid_q;
    assign m_axis_tdata   = out_data_q;
    assign m_axis_tkeep   = out_keep_q;
    assign m_axis_tlast   = out_last_q;
    assign overflow_cnt_o = ovf_q;
    assign busy_o         = (fill_q != '0) || out_valid_q || last_pend_q;

endmodule

// File: tb/tb_uart_axis_packer.sv
// Bench for uart_axis_packer: a 512-bit and a 32-bit instance checked against queued beats.
module tb_uart_axis_packer;
    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
    } beat_t;

    logic clk;
    logic rst_n;

    logic         a_bv, a_done, a_tvalid, a_tready, a_tlast, a_busy;
    logic [7:0]   a_bd;
    logic [511:0] a_tdata;
    logic [63:0]  a_tkeep;
    logic [15:0]  a_ovf;

    logic         b_bv, b_done, b_tvalid, b_tready, b_tlast, b_busy;
    logic [7:0]   b_bd;
    logic [31:0]  b_tdata;
    logic [3:0]   b_tkeep;
    logic [15:0]  b_ovf;

    beat_t qa[$];
    beat_t qb[$];
    int    checks   = 0;
    int    failures = 0;

    uart_axis_packer #(
        .C_AXIS_TDATA_WIDTH(512),
        .C_IDLE_TIMEOUT    (16),
        .C_CNT_WIDTH       (16)
    ) u_dut_a (
        .s_axis_aclk   (clk),
        .rst_n         (rst_n),
        .byte_valid_i  (a_bv),
        .byte_data_i   (a_bd),
        .done_i        (a_done),
        .m_axis_tvalid (a_tvalid),
        .m_axis_tready (a_tready),
        .m_axis_tdata  (a_tdata),
        .m_axis_tkeep  (a_tkeep),
        .m_axis_tlast  (a_tlast),
        .overflow_cnt_o(a_ovf),
        .busy_o        (a_busy)
    );

    uart_axis_packer #(
        .C_AXIS_TDATA_WIDTH(32),
        .C_IDLE_TIMEOUT    (16),
        .C_CNT_WIDTH       (16)
    ) u_dut_b (
        .s_axis_aclk   (clk),
        .rst_n         (rst_n),
        .byte_valid_i  (b_bv),
        .byte_data_i   (b_bd),
        .done_i        (b_done),
        .m_axis_tvalid (b_tvalid),
        .m_axis_tready (b_tready),
        .m_axis_tdata  (b_tdata),
        .m_axis_tkeep  (b_tkeep),
        .m_axis_tlast  (b_tlast),
        .overflow_cnt_o(b_ovf),
        .busy_o        (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] v);
        a_bv = 1'b1;
        a_bd = v;
        tick();
        a_bv = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] v);
        b_bv = 1'b1;
        b_bd = v;
        tick();
        b_bv = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (a_tvalid !== 1'b0 || a_tlast !== 1'b0 || a_tkeep !== 64'd0 || a_tdata !== 512'd0) begin
            failures++;
            $display("FAIL reset_a_out got valid=%b last=%b keep=%h exp all zero",
                     a_tvalid, a_tlast, a_tkeep);
        end
        checks++;
        if (a_ovf !== 16'd0 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_a_status got ovf=%0d busy=%b exp 0 0", a_ovf, a_busy);
        end
        checks++;
        if (b_tvalid !== 1'b0 || b_busy !== 1'b0 || b_ovf !== 16'd0) begin
            failures++;
            $display("FAIL reset_b got valid=%b busy=%b ovf=%0d exp 0 0 0", b_tvalid, b_busy, b_ovf);
        end
    endtask

    task automatic test_basic_pack();
        beat_t e;
        int    n;
        e = '0;
        for (int k = 0; k < 64; k++) begin
            e.data[8*k +: 8] = 8'(k);
        end
        e.keep = '1;
        e.last = 1'b0;
        qa.push_back(e);
        for (int k = 0; k < 64; k++) begin
            send_a(8'(k));
            if (k != 63) begin
                tick(); tick(); tick();
            end
        end
        n = 0;
        while (a_tvalid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != 1) begin
            failures++;
            $display("FAIL basic_latency got=%0d cycles exp=1", n);
        end
        for (int c = 0; c < 100 && qa.size() != 0; c++) begin
            if (a_tvalid === 1'b1 && a_tready === 1'b1) begin
                e = qa.pop_front();
                checks++;
                if (a_tdata !== e.data || a_tkeep !== e.keep || a_tlast !== e.last) begin
                    failures++;
                    $display("FAIL basic_beat got data=%h keep=%h last=%b exp data=%h keep=%h last=%b",
                             a_tdata, a_tkeep, a_tlast, e.data, e.keep, e.last);
                end
            end
            tick();
        end
        checks++;
        if (qa.size() != 0 || a_ovf !== 16'd0) begin
            failures++;
            $display("FAIL basic_done got pending=%0d ovf=%0d exp 0 0", qa.size(), a_ovf);
        end
    endtask

    task automatic test_timeout();
        beat_t e;
        int    n;
        e = '0;
        e.data[23:0] = 24'h434241;
        e.keep = 64'h7;
        qa.push_back(e);
        send_a(8'h41);
        send_a(8'h42);
        send_a(8'h43);
        n = 0;
        while (a_tvalid !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (n != 17) begin
            failures++;
            $display("FAIL timeout_latency got=%0d cycles exp=17", n);
        end
        for (int c = 0; c < 100 && qa.size() != 0; c++) begin
            if (a_tvalid === 1'b1 && a_tready === 1'b1) begin
                e = qa.pop_front();
                checks++;
                if (a_tdata !== e.data || a_tkeep !== e.keep || a_tlast !== e.last) begin
                    failures++;
                    $display("FAIL timeout_beat got data=%h keep=%h last=%b exp data=%h keep=%h last=%b",
                             a_tdata, a_tkeep, a_tlast, e.data, e.keep, e.last);
                end
            end
            tick();
        end
        checks++;
        if (qa.size() != 0) begin
            failures++;
            $display("FAIL timeout_wait got pending=%0d exp 0", qa.size());
        end
    endtask

    task automatic test_done();
        beat_t e;
        e = '0;
        e.data[39:0] = 40'h6463626160;
        e.keep = 64'h1F;
        e.last = 1'b1;
        qa.push_back(e);
        e = '0;
        e.last = 1'b1;
        qa.push_back(e);
        for (int k = 0; k < 5; k++) begin
            send_a(8'(8'h60 + k));
        end
        a_done = 1'b1;
        for (int c = 0; c < 100 && qa.size() == 2; c++) begin
            if (a_tvalid === 1'b1 && a_tready === 1'b1) begin
                e = qa.pop_front();
                checks++;
                if (a_tdata !== e.data || a_tkeep !== e.keep || a_tlast !== e.last) begin
                    failures++;
                    $display("FAIL done_beat got data=%h keep=%h last=%b exp data=%h keep=%h last=%b",
                             a_tdata, a_tkeep, a_tlast, e.data, e.keep, e.last);
                end
            end
            tick();
        end
        a_done = 1'b0;
        tick(); tick();
        checks++;
        if (a_busy !== 1'b0 || a_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL done_idle got busy=%b valid=%b exp 0 0", a_busy, a_tvalid);
        end
        a_done = 1'b1;
        for (int c = 0; c < 100 && qa.size() != 0; c++) begin
            if (a_tvalid === 1'b1 && a_tready === 1'b1) begin
                e = qa.pop_front();
                checks++;
                if (a_tdata !== e.data || a_tkeep !== e.keep || a_tlast !== e.last) begin
                    failures++;
                    $display("FAIL done_marker got data=%h keep=%h last=%b exp data=%h keep=%h last=%b",
                             a_tdata, a_tkeep, a_tlast, e.data, e.keep, e.last);
                end
            end
            tick();
        end
        a_done = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (qa.size() != 0 || a_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL done_extra got pending=%0d valid=%b exp 0 0", qa.size(), a_tvalid);
        end
    endtask

    task automatic test_backpressure();
        beat_t e;
        b_tready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            send_b(8'(8'h10 + k));
        end
        checks++;
        if (b_tvalid !== 1'b1 || b_tdata !== 32'h13121110 || b_tkeep !== 4'hF) begin
            failures++;
            $display("FAIL bp_hold got valid=%b data=%h keep=%h exp 1 13121110 f",
                     b_tvalid, b_tdata, b_tkeep);
        end
        checks++;
        if (b_ovf !== 16'd2 || b_busy !== 1'b1) begin
            failures++;
            $display("FAIL bp_ovf got ovf=%0d busy=%b exp 2 1", b_ovf, b_busy);
        end
        tick(); tick(); tick();
        checks++;
        if (b_tvalid !== 1'b1 || b_tdata !== 32'h13121110 || b_tlast !== 1'b0) begin
            failures++;
            $display("FAIL bp_stable got valid=%b data=%h last=%b exp 1 13121110 0",
                     b_tvalid, b_tdata, b_tlast);
        end
        e = '0;
        e.data[31:0] = 32'h13121110;
        e.keep = 64'hF;
        qb.push_back(e);
        e.data[31:0] = 32'h17161514;
        qb.push_back(e);
        b_tready = 1'b1;
        for (int c = 0; c < 100 && qb.size() != 0; c++) begin
            if (b_tvalid === 1'b1 && b_tready === 1'b1) begin
                e = qb.pop_front();
                checks++;
                if (b_tdata !== e.data[31:0] || b_tkeep !== e.keep[3:0] || b_tlast !== e.last) begin
                    failures++;
                    $display("FAIL bp_beat got data=%h keep=%h last=%b exp data=%h keep=%h last=%b",
                             b_tdata, b_tkeep, b_tlast, e.data[31:0], e.keep[3:0], e.last);
                end
            end
            tick();
        end
        checks++;
        if (qb.size() != 0 || b_busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain got pending=%0d busy=%b exp 0 0", qb.size(), b_busy);
        end
    endtask

    task automatic test_same_cycle();
        beat_t e;
        e = '0;
        e.data[31:0] = 32'h23222120;
        e.keep = 64'hF;
        qb.push_back(e);
        e = '0;
        e.data[7:0] = 8'h24;
        e.keep = 64'h1;
        qb.push_back(e);
        for (int k = 0; k < 5; k++) begin
            send_b(8'(8'h20 + k));
        end
        checks++;
        if (b_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL same_latency got valid=%b exp 1", b_tvalid);
        end
        for (int c = 0; c < 100 && qb.size() != 0; c++) begin
            if (b_tvalid === 1'b1 && b_tready === 1'b1) begin
                e = qb.pop_front();
                checks++;
                if (b_tdata !== e.data[31:0] || b_tkeep !== e.keep[3:0] || b_tlast !== e.last) begin
                    failures++;
                    $display("FAIL same_beat got data=%h keep=%h last=%b exp data=%h keep=%h last=%b",
                             b_tdata, b_tkeep, b_tlast, e.data[31:0], e.keep[3:0], e.last);
                end
            end
            tick();
        end
        checks++;
        if (qb.size() != 0 || b_ovf !== 16'd2) begin
            failures++;
            $display("FAIL same_end got pending=%0d ovf=%0d exp 0 2", qb.size(), b_ovf);
        end
    endtask

    task automatic test_reset_mid();
        beat_t e;
        b_tready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            send_b(8'(8'h30 + k));
        end
        checks++;
        if (b_tvalid !== 1'b1 || b_busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got valid=%b busy=%b exp 1 1", b_tvalid, b_busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (b_tvalid !== 1'b0 || b_busy !== 1'b0 || b_ovf !== 16'd0 || b_tkeep !== 4'h0) begin
            failures++;
            $display("FAIL rstmid_async got valid=%b busy=%b ovf=%0d keep=%h exp 0 0 0 0",
                     b_tvalid, b_busy, b_ovf, b_tkeep);
        end
        tick();
        rst_n = 1'b1;
        tick();
        b_tready = 1'b1;
        e = '0;
        e.data[31:0] = 32'h53525150;
        e.keep = 64'hF;
        qb.push_back(e);
        for (int k = 0; k < 4; k++) begin
            send_b(8'(8'h50 + k));
        end
        for (int c = 0; c < 100 && qb.size() != 0; c++) begin
            if (b_tvalid === 1'b1 && b_tready === 1'b1) begin
                e = qb.pop_front();
                checks++;
                if (b_tdata !== e.data[31:0] || b_tkeep !== e.keep[3:0] || b_tlast !== e.last) begin
                    failures++;
                    $display("FAIL rstmid_beat got data=%h keep=%h last=%b exp data=%h keep=%h last=%b",
                             b_tdata, b_tkeep, b_tlast, e.data[31:0], e.keep[3:0], e.last);
                end
            end
            tick();
        end
        checks++;
        if (qb.size() != 0 || b_busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_drain got pending=%0d busy=%b exp 0 0", qb.size(), b_busy);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        a_bv     = 1'b0;
        a_bd     = 8'h00;
        a_done   = 1'b0;
        a_tready = 1'b1;
        b_bv     = 1'b0;
        b_bd     = 8'h00;
        b_done   = 1'b0;
        b_tready = 1'b1;
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_basic_pack();
        test_timeout();
        test_done();
        test_backpressure();
        test_same_cycle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
